// File: rtl/rr_grant_arbiter_pkg.sv
// arb_pkg: shared constants, FSM state type and one-hot helper for the round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 5;
    localparam int ID_W  = $clog2(N_REQ);
    typedef enum logic {IDLE, OWNED} arb_state_e;
    function automatic logic [N_REQ-1:0] onehot_of(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between requesters (master) and arbiter (slave)
//   req      per-requester request level
//   done     single-cycle tenure-end pulse from the current owner
//   grant    one-hot or zero grant vector
//   grant_id binary index of the granted requester, 0 when idle
//   busy     high while any grant is asserted
interface rr_grant_arbiter_if;
    import arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    modport master (output req, done, input grant, grant_id, busy);
    modport slave  (input req, done, output grant, grant_id, busy);
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// rr_pick: combinational rotating-priority search for the first request at or above a pointer
//   i_req       request vector
//   i_mask_en   drop bit i_mask_id from the search
//   i_mask_id   index of the bit to drop
//   i_prio_ptr  index holding highest priority
//   o_found     some request was eligible
//   o_winner_id index of the winning request
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_mask_en,
    input  logic [ID_W-1:0]  i_mask_id,
    input  logic [ID_W-1:0]  i_prio_ptr,
    output logic             o_found,
    output logic [ID_W-1:0]  o_winner_id
);
    logic [N_REQ-1:0]   w_req;
    logic [N_REQ-1:0]   w_below;
    logic [2*N_REQ-1:0] w_dbl;

    assign w_req   = i_req & ~(i_mask_en ? onehot_of(i_mask_id) : '0);
    assign w_below = (N_REQ'(1) << i_prio_ptr) - N_REQ'(1);
    // Lower copy holds only bits at/above the pointer; the upper copy supplies the wrap-around,
    // so the lowest set bit of the doubled vector is the round-robin winner.
    assign w_dbl   = {w_req, w_req & ~w_below};

    always_comb begin
        o_found     = 1'b0;
        o_winner_id = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                o_found     = 1'b1;
                o_winner_id = ID_W'(i % N_REQ);
            end
        end
    end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with held grants, done release and hold-time limit
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   slave side of rr_grant_arbiter_if (req, done in; grant, grant_id, busy out)
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_arbiter_if.slave  bus
);
    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e        r_state, w_state_nx;
    logic [N_REQ-1:0]  r_grant, w_grant_nx;
    logic [ID_W-1:0]   r_grant_id, w_id_nx;
    logic [ID_W-1:0]   r_prio_ptr, w_ptr_nx;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nx;
    logic              w_owner_req;
    logic              w_release;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;

    assign w_owner_req = bus.req[r_grant_id];
    assign w_release   = bus.done | ~w_owner_req | (MAX_HOLD != 0 && r_hold_cnt == HOLD_LAST);

    rr_pick u_pick (
        .i_req       (bus.req),
        .i_mask_en   ((r_state == OWNED) & ~w_owner_req),
        .i_mask_id   (r_grant_id),
        .i_prio_ptr  (r_prio_ptr),
        .o_found     (w_found),
        .o_winner_id (w_winner)
    );

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_id_nx    = r_grant_id;
        w_ptr_nx   = r_prio_ptr;
        w_hold_nx  = r_hold_cnt;
        if (r_state == IDLE || w_release) begin
            w_state_nx = w_found ? OWNED : IDLE;
            w_grant_nx = w_found ? onehot_of(w_winner) : '0;
            w_id_nx    = w_found ? w_winner : '0;
            w_ptr_nx   = !w_found ? r_prio_ptr : (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
            w_hold_nx  = '0;
        end else if (MAX_HOLD != 0 && r_hold_cnt != HOLD_LAST) begin
            w_hold_nx = r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_prio_ptr <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_grant_id <= w_id_nx;
            r_prio_ptr <= w_ptr_nx;
            r_hold_cnt <= w_hold_nx;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = (r_state == OWNED);
endmodule
